// File: rtl/seq_generator_if.sv
// seq_generator handshake/bus bundle.
// Master drives the request side, slave returns the serial stream.
interface seq_generator_if #(
  parameter int PAT_W = 6
);
  logic             start;
  logic             use_def;
  logic [PAT_W-1:0] pat_in;
  logic [3:0]       rep;
  logic [2:0]       gap;
  logic             abort;
  logic             ready;
  logic             x;
  logic             x_valid;
  logic             done;

  modport master (
    output start,
    output use_def,
    output pat_in,
    output rep,
    output gap,
    output abort,
    input  ready,
    input  x,
    input  x_valid,
    input  done
  );

  modport slave (
    input  start,
    input  use_def,
    input  pat_in,
    input  rep,
    input  gap,
    input  abort,
    output ready,
    output x,
    output x_valid,
    output done
  );
endinterface

// File: rtl/seq_generator.sv
// Serial pattern generator: sends a captured pattern MSB first,
// rep times with gap idle cycles between, then a one-cycle done.
module seq_generator #(
  parameter int             PAT_W   = 6,
  parameter logic [PAT_W-1:0] PAT_DEF = 6'b110011
) (
  input  logic           clk,
  input  logic           reset,
  seq_generator_if.slave bus
);

  localparam int IW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IW-1:0] LAST = IW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FIN
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] sh_q;
  logic [IW-1:0]    bit_idx;
  logic [3:0]       rep_left;
  logic [2:0]       gap_q;
  logic [2:0]       gap_cnt;

  logic [PAT_W-1:0] pat_sel;
  logic [3:0]       rep_sel;

  assign pat_sel = bus.use_def ? PAT_DEF : bus.pat_in;
  assign rep_sel = (bus.rep == 4'd0) ? 4'd1 : bus.rep;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pat_q       <= '0;
      sh_q        <= '0;
      bit_idx     <= '0;
      rep_left    <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      bus.ready   <= 1'b1;
      bus.x       <= 1'b0;
      bus.x_valid <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.done <= 1'b0;
          // abort wins over a same-cycle start
          if (bus.start && !bus.abort) begin
            state       <= SEND;
            pat_q       <= pat_sel;
            sh_q        <= pat_sel << 1;
            bit_idx     <= LAST;
            rep_left    <= rep_sel - 4'd1;
            gap_q       <= bus.gap;
            gap_cnt     <= '0;
            bus.ready   <= 1'b0;
            bus.x       <= pat_sel[PAT_W-1];
            bus.x_valid <= 1'b1;
          end
        end

        SEND: begin
          if (bus.abort) begin
            state       <= IDLE;
            bus.ready   <= 1'b1;
            bus.x       <= 1'b0;
            bus.x_valid <= 1'b0;
          end else if (bit_idx != '0) begin
            bit_idx <= bit_idx - 1'b1;
            sh_q    <= sh_q << 1;
            bus.x   <= sh_q[PAT_W-1];
          end else if (rep_left != 4'd0) begin
            rep_left <= rep_left - 4'd1;
            if (gap_q != 3'd0) begin
              state       <= GAP;
              gap_cnt     <= gap_q - 3'd1;
              bus.x       <= 1'b0;
              bus.x_valid <= 1'b0;
            end else begin
              // back-to-back repetition, no bubble
              bit_idx <= LAST;
              sh_q    <= pat_q << 1;
              bus.x   <= pat_q[PAT_W-1];
            end
          end else begin
            state       <= FIN;
            bus.done    <= 1'b1;
            bus.x       <= 1'b0;
            bus.x_valid <= 1'b0;
          end
        end

        GAP: begin
          if (bus.abort) begin
            state       <= IDLE;
            bus.ready   <= 1'b1;
            bus.x       <= 1'b0;
            bus.x_valid <= 1'b0;
          end else if (gap_cnt == 3'd0) begin
            state       <= SEND;
            bit_idx     <= LAST;
            sh_q        <= pat_q << 1;
            bus.x       <= pat_q[PAT_W-1];
            bus.x_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end

        FIN: begin
          // done is already committed; abort has no effect here
          state     <= IDLE;
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          bus.ready   <= 1'b1;
          bus.x       <= 1'b0;
          bus.x_valid <= 1'b0;
          bus.done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// Directed self-checking bench for seq_generator.
// Each task drives one scenario and checks against hand-made tables.
module tb_seq_generator;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic rx [64];
  logic rv [64];
  logic rd [64];
  logic rr [64];

  seq_generator_if #(.PAT_W(6)) bus ();

  seq_generator #(
    .PAT_W  (6),
    .PAT_DEF(6'b110011)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic ud, input logic [5:0] p,
                    input logic [3:0] r, input logic [2:0] g);
    bus.start   = 1'b1;
    bus.use_def = ud;
    bus.pat_in  = p;
    bus.rep     = r;
    bus.gap     = g;
    step();
    bus.start   = 1'b0;
    bus.use_def = 1'b0;
    bus.pat_in  = 6'b000000;
    bus.rep     = 4'd0;
    bus.gap     = 3'd0;
  endtask

  task automatic record(input int n);
    for (int k = 0; k < n; k++) begin
      rx[k] = bus.x;
      rv[k] = bus.x_valid;
      rd[k] = bus.done;
      rr[k] = bus.ready;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests++;
    if ({bus.ready, bus.x, bus.x_valid, bus.done} !== 4'b1000) begin
      fails++;
      $display("FAIL in_reset: rdy/x/v/done=%b want 1000",
               {bus.ready, bus.x, bus.x_valid, bus.done});
    end
    reset = 1'b0;
    step();
    tests++;
    if ({bus.ready, bus.x, bus.x_valid, bus.done} !== 4'b1000) begin
      fails++;
      $display("FAIL post_reset: rdy/x/v/done=%b want 1000",
               {bus.ready, bus.x, bus.x_valid, bus.done});
    end
  endtask

  task automatic test_def_single();
    logic [7:0] ex, ev, ed, er;
    ex = 8'b11001100;
    ev = 8'b11111100;
    ed = 8'b00000010;
    er = 8'b00000001;
    go(1'b1, 6'b000000, 4'd1, 3'd0);
    record(8);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if ({rx[k], rv[k], rd[k], rr[k]} !==
          {ex[7-k], ev[7-k], ed[7-k], er[7-k]}) begin
        fails++;
        $display("FAIL def_single t+%0d: x/v/d/r=%b want %b", k + 1,
                 {rx[k], rv[k], rd[k], rr[k]},
                 {ex[7-k], ev[7-k], ed[7-k], er[7-k]});
      end
    end
  endtask

  task automatic test_gap();
    logic [15:0] ex, ev, ed, er;
    ex = 16'b1100110011001100;
    ev = 16'b1111110011111100;
    ed = 16'b0000000000000010;
    er = 16'b0000000000000001;
    go(1'b1, 6'b000000, 4'd2, 3'd2);
    record(16);
    for (int k = 0; k < 16; k++) begin
      tests++;
      if ({rx[k], rv[k], rd[k], rr[k]} !==
          {ex[15-k], ev[15-k], ed[15-k], er[15-k]}) begin
        fails++;
        $display("FAIL gap2 t+%0d: x/v/d/r=%b want %b", k + 1,
                 {rx[k], rv[k], rd[k], rr[k]},
                 {ex[15-k], ev[15-k], ed[15-k], er[15-k]});
      end
    end
  endtask

  task automatic test_user_rep0();
    logic [7:0] ex, ev, ed, er;
    ex = 8'b10100100;
    ev = 8'b11111100;
    ed = 8'b00000010;
    er = 8'b00000001;
    go(1'b0, 6'b101001, 4'd0, 3'd5);
    record(8);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if ({rx[k], rv[k], rd[k], rr[k]} !==
          {ex[7-k], ev[7-k], ed[7-k], er[7-k]}) begin
        fails++;
        $display("FAIL user_rep0 t+%0d: x/v/d/r=%b want %b", k + 1,
                 {rx[k], rv[k], rd[k], rr[k]},
                 {ex[7-k], ev[7-k], ed[7-k], er[7-k]});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] ex, ev, ed, er;
    ex = 20'b11001111001111001100;
    ev = 20'b11111111111111111100;
    ed = 20'b00000000000000000010;
    er = 20'b00000000000000000001;
    go(1'b1, 6'b000000, 4'd3, 3'd0);
    record(20);
    for (int k = 0; k < 20; k++) begin
      tests++;
      if ({rx[k], rv[k], rd[k], rr[k]} !==
          {ex[19-k], ev[19-k], ed[19-k], er[19-k]}) begin
        fails++;
        $display("FAIL b2b t+%0d: x/v/d/r=%b want %b", k + 1,
                 {rx[k], rv[k], rd[k], rr[k]},
                 {ex[19-k], ev[19-k], ed[19-k], er[19-k]});
      end
    end
  endtask

  task automatic test_abort_send();
    logic seen_done;
    go(1'b1, 6'b000000, 4'd2, 3'd1);
    tests++;
    if (bus.x_valid !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: x_valid=%b want 1", bus.x_valid);
    end
    step();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    tests++;
    if ({bus.x_valid, bus.ready, bus.x} !== 3'b010) begin
      fails++;
      $display("FAIL abort_t4: v/r/x=%b want 010",
               {bus.x_valid, bus.ready, bus.x});
    end
    seen_done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      seen_done = seen_done | bus.done | bus.x_valid;
      step();
    end
    tests++;
    if (seen_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_quiet: done/valid seen=%b want 0", seen_done);
    end
  endtask

  task automatic test_abort_gap();
    go(1'b1, 6'b000000, 4'd2, 3'd3);
    for (int k = 0; k < 6; k++) step();
    tests++;
    if ({bus.x_valid, bus.ready} !== 2'b00) begin
      fails++;
      $display("FAIL in_gap: v/r=%b want 00", {bus.x_valid, bus.ready});
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    step();
    step();
    tests++;
    if ({bus.x_valid, bus.ready, bus.done} !== 3'b010) begin
      fails++;
      $display("FAIL abort_gap: v/r/d=%b want 010",
               {bus.x_valid, bus.ready, bus.done});
    end
  endtask

  task automatic test_abort_start();
    bus.abort = 1'b1;
    go(1'b1, 6'b000000, 4'd1, 3'd0);
    bus.abort = 1'b0;
    tests++;
    if ({bus.x_valid, bus.ready} !== 2'b01) begin
      fails++;
      $display("FAIL abort_start: v/r=%b want 01",
               {bus.x_valid, bus.ready});
    end
    step();
    tests++;
    if ({bus.x_valid, bus.ready} !== 2'b01) begin
      fails++;
      $display("FAIL abort_start_hold: v/r=%b want 01",
               {bus.x_valid, bus.ready});
    end
  endtask

  task automatic test_fin_inputs();
    go(1'b1, 6'b000000, 4'd1, 3'd0);
    for (int k = 0; k < 6; k++) step();
    bus.abort   = 1'b1;
    bus.start   = 1'b1;
    bus.use_def = 1'b1;
    bus.rep     = 4'd1;
    tests++;
    if ({bus.done, bus.ready, bus.x_valid} !== 3'b100) begin
      fails++;
      $display("FAIL fin_done: d/r/v=%b want 100",
               {bus.done, bus.ready, bus.x_valid});
    end
    step();
    bus.abort   = 1'b0;
    bus.start   = 1'b0;
    bus.use_def = 1'b0;
    bus.rep     = 4'd0;
    tests++;
    if ({bus.done, bus.ready, bus.x_valid} !== 3'b010) begin
      fails++;
      $display("FAIL fin_next: d/r/v=%b want 010",
               {bus.done, bus.ready, bus.x_valid});
    end
    step();
    tests++;
    if ({bus.done, bus.ready, bus.x_valid} !== 3'b010) begin
      fails++;
      $display("FAIL fin_start_ignored: d/r/v=%b want 010",
               {bus.done, bus.ready, bus.x_valid});
    end
  endtask

  task automatic test_reset_mid();
    logic       seen;
    logic [7:0] ex, ev, ed, er;
    go(1'b1, 6'b000000, 4'd1, 3'd0);
    step();
    bus.start   = 1'b1;
    bus.use_def = 1'b0;
    bus.pat_in  = 6'b111111;
    bus.rep     = 4'd4;
    step();
    bus.start   = 1'b0;
    bus.pat_in  = 6'b000000;
    bus.rep     = 4'd0;
    tests++;
    if ({bus.x, bus.x_valid} !== 2'b01) begin
      fails++;
      $display("FAIL busy_start_t3: x/v=%b want 01",
               {bus.x, bus.x_valid});
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if ({bus.ready, bus.x, bus.x_valid, bus.done} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_mid_t5: r/x/v/d=%b want 1000",
               {bus.ready, bus.x, bus.x_valid, bus.done});
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      seen = seen | bus.x_valid | bus.done | ~bus.ready;
      step();
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_quiet: activity=%b want 0", seen);
    end
    ex = 8'b11001100;
    ev = 8'b11111100;
    ed = 8'b00000010;
    er = 8'b00000001;
    go(1'b1, 6'b000000, 4'd1, 3'd0);
    record(8);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if ({rx[k], rv[k], rd[k], rr[k]} !==
          {ex[7-k], ev[7-k], ed[7-k], er[7-k]}) begin
        fails++;
        $display("FAIL after_reset t+%0d: x/v/d/r=%b want %b", k + 1,
                 {rx[k], rv[k], rd[k], rr[k]},
                 {ex[7-k], ev[7-k], ed[7-k], er[7-k]});
      end
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.use_def = 1'b0;
    bus.pat_in  = 6'b000000;
    bus.rep     = 4'd0;
    bus.gap     = 3'd0;
    bus.abort   = 1'b0;
    test_reset();
    test_def_single();
    test_gap();
    test_user_rep0();
    test_back_to_back();
    test_abort_send();
    test_abort_gap();
    test_abort_start();
    test_fin_inputs();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
